// File: rtl/sprite_render_sequencer.sv
// sprite_render_sequencer
//   Frame sequencer for the 160x120 game screen. Each frame tick runs an
//   optional INIT phase, an ERASE pass over all sprites, one LOAD cycle, a
//   DRAW pass and one COMP (collision compare) cycle, then returns to IDLE.
//   A collision seen at COMP forces one more ERASE pass (blanking the sprites)
//   and, with the collision still present, parks in OVER until reset.
//
//   Build option: define DIRTY_SKIP_EN to skip sprites whose dirty bit is 0
//   in both passes (OR'd with skip_mask). The forced post-collision erase
//   ignores dirty so every sprite is blanked.
//
// Ports
//   clock, reset_n        clock, asynchronous active-low reset
//   frame_go              frame tick pulse
//   need_init / init_done init phase request / handshake
//   dead                  collision result
//   skip_mask, dirty      per-sprite disable / moved flags
//   init_req              high throughout INIT
//   sprite_sel, loc       sprite addressed, row-major pixel index
//   px, py                column / row of loc inside the sprite
//   plot_en, erase        pixel write strobe, high for the whole erase pass
//   load, comp            one-cycle strobes
//   busy                  state is neither IDLE nor OVER
//   game_over, overrun    sticky flags
module sprite_render_sequencer #(
  parameter int NUM_SPRITES = 6,
  parameter int SPR_W       = 5,
  parameter int SPR_H       = 5,
  parameter int SEL_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1,
  parameter int LOC_W       = (SPR_W*SPR_H > 1) ? $clog2(SPR_W*SPR_H) : 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   frame_go,
  input  logic                   need_init,
  input  logic                   init_done,
  input  logic                   dead,
  input  logic [NUM_SPRITES-1:0] skip_mask,
  input  logic [NUM_SPRITES-1:0] dirty,
  output logic                   init_req,
  output logic [SEL_W-1:0]       sprite_sel,
  output logic [LOC_W-1:0]       loc,
  output logic [7:0]             px,
  output logic [6:0]             py,
  output logic                   plot_en,
  output logic                   erase,
  output logic                   load,
  output logic                   comp,
  output logic                   busy,
  output logic                   game_over,
  output logic                   overrun
);

  typedef enum logic [2:0] {IDLE, INIT, ERASE, LOAD, DRAW, COMP, OVER} state_t;

  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_SPRITES-1);
  localparam logic [LOC_W-1:0] LOC_LAST = LOC_W'(SPR_W*SPR_H-1);
  localparam logic [7:0]       PX_LAST  = 8'(SPR_W-1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [LOC_W-1:0] loc_q, loc_d;
  logic [7:0]       px_q, px_d;
  logic [6:0]       py_q, py_d;
  logic             blank_q, blank_d;   // current ERASE is the post-collision blanking pass
  logic             game_over_q, game_over_d;
  logic             overrun_q, overrun_d;
  logic             in_pass, skip_bit, skip_now;

`ifdef DIRTY_SKIP_EN
  assign skip_bit = skip_mask[sel_q] | (~dirty[sel_q] & ~blank_q);
`else
  logic unused_in;
  assign unused_in = ^{dirty, blank_q};
  assign skip_bit  = skip_mask[sel_q];
`endif

  assign in_pass  = (state_q == ERASE) || (state_q == DRAW);
  // A skipped sprite is detected on its first cycle and burns just that one.
  assign skip_now = in_pass && (loc_q == '0) && skip_bit;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    loc_d       = loc_q;
    px_d        = px_q;
    py_d        = py_q;
    blank_d     = blank_q;
    overrun_d   = overrun_q | (frame_go & busy);
    case (state_q)
      IDLE:  if (frame_go) state_d = need_init ? INIT : ERASE;
      INIT:  if (init_done) state_d = ERASE;
      ERASE, DRAW: begin
        if (skip_now || loc_q == LOC_LAST) begin
          loc_d = '0;
          px_d  = '0;
          py_d  = '0;
          if (sel_q == SEL_LAST) begin
            sel_d = '0;
            if (state_q == ERASE) begin
              blank_d = 1'b0;
              state_d = dead ? OVER : LOAD;
            end else begin
              state_d = COMP;
            end
          end else begin
            sel_d = sel_q + 1'b1;
          end
        end else begin
          loc_d = loc_q + 1'b1;
          if (px_q == PX_LAST) begin
            px_d = '0;
            py_d = py_q + 1'b1;
          end else begin
            px_d = px_q + 1'b1;
          end
        end
      end
      LOAD:  state_d = DRAW;
      COMP: begin
        if (dead) begin
          state_d = ERASE;
          blank_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: ;  // OVER holds until reset
    endcase
    game_over_d = game_over_q | (state_d == OVER);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      loc_q       <= '0;
      px_q        <= '0;
      py_q        <= '0;
      blank_q     <= 1'b0;
      game_over_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      loc_q       <= loc_d;
      px_q        <= px_d;
      py_q        <= py_d;
      blank_q     <= blank_d;
      game_over_q <= game_over_d;
      overrun_q   <= overrun_d;
    end
  end

  assign init_req   = (state_q == INIT);
  assign sprite_sel = sel_q;
  assign loc        = loc_q;
  assign px         = px_q;
  assign py         = py_q;
  assign plot_en    = in_pass && !skip_now;
  assign erase      = (state_q == ERASE);
  assign load       = (state_q == LOAD);
  assign comp       = (state_q == COMP);
  assign busy       = (state_q != IDLE) && (state_q != OVER);
  assign game_over  = game_over_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_sprite_render_sequencer.sv
// Directed bench for sprite_render_sequencer with NUM_SPRITES=4, 5x5 sprites.
module tb_sprite_render_sequencer;
  localparam int N = 4;

  logic       clock = 1'b0, reset_n = 1'b0;
  logic       frame_go = 0, need_init = 0, init_done = 0, dead = 0;
  logic [N-1:0] skip_mask = '0, dirty = '0;
  logic       init_req, plot_en, erase, load, comp, busy, game_over, overrun;
  logic [1:0] sprite_sel;
  logic [4:0] loc;
  logic [7:0] px;
  logic [6:0] py;

  int checks = 0, errors = 0;

  sprite_render_sequencer #(.NUM_SPRITES(N), .SPR_W(5), .SPR_H(5)) dut (
    .clock(clock), .reset_n(reset_n), .frame_go(frame_go), .need_init(need_init),
    .init_done(init_done), .dead(dead), .skip_mask(skip_mask), .dirty(dirty),
    .init_req(init_req), .sprite_sel(sprite_sel), .loc(loc), .px(px), .py(py),
    .plot_en(plot_en), .erase(erase), .load(load), .comp(comp), .busy(busy),
    .game_over(game_over), .overrun(overrun));

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // frame statistics
  int busy_c, erase_c, erase_plot, draw_plot, load_c, comp_c, init_c, bad_seq;

  // Pulse frame_go, then follow the frame until busy drops.
  task automatic run_frame(input int init_wait, input bit dead_at_comp, input int go_at_draw);
    int ek, dk;
    busy_c = 0; erase_c = 0; erase_plot = 0; draw_plot = 0; load_c = 0;
    comp_c = 0; init_c = 0; bad_seq = 0; ek = 0; dk = 0;
    frame_go = 1; step(); frame_go = 0;
    for (int cyc = 0; cyc < 3000 && busy; cyc++) begin
      busy_c++;
      if (erase) erase_c++;
      if (load) load_c++;
      if (comp) begin comp_c++; if (dead_at_comp) dead = 1; end
      if (plot_en) begin
        int k;
        k = erase ? ek : dk;
        if (sprite_sel !== 2'(k/25) || loc !== 5'(k%25) || px !== 8'(k%5) || py !== 7'((k%25)/5))
          bad_seq++;
        if (erase) begin ek++; erase_plot++; end else begin dk++; draw_plot++; end
      end
      frame_go = (go_at_draw != 0 && !erase && plot_en && draw_plot == go_at_draw);
      if (init_req) begin init_c++; init_done = (init_c == init_wait); end
      else init_done = 0;
      step();
    end
    frame_go = 0; init_done = 0;
    chk("frame_terminates", int'(busy), 0);
  endtask

  initial begin
    int dirty_len;
    #12;
    // reset state
    chk("rst_busy", int'(busy), 0);
    chk("rst_outs", int'({init_req, plot_en, erase, load, comp, game_over, overrun}), 0);
    chk("rst_addr", int'({sprite_sel, loc, px, py}), 0);
    reset_n = 1; step();

    // 1: plain frame
    run_frame(0, 0, 0);
    chk("t1_busy", busy_c, 202);
    chk("t1_erase_plot", erase_plot, 100);
    chk("t1_draw_plot", draw_plot, 100);
    chk("t1_load", load_c, 1);
    chk("t1_comp", comp_c, 1);
    chk("t1_seq", bad_seq, 0);
    chk("t1_idle_sel", int'(sprite_sel), 0);
    chk("t1_no_overrun", int'(overrun), 0);

    // 2: init phase with init_done after 7 cycles
    need_init = 1;
    run_frame(7, 0, 0);
    need_init = 0;
    chk("t2_init_cycles", init_c, 7);
    chk("t2_busy", busy_c, 209);
    chk("t2_seq", bad_seq, 0);
    chk("t2_erase", erase_c, 100);

    // 3: sprite 1 masked
    skip_mask = 4'b0010;
    run_frame(0, 0, 0);
    skip_mask = '0;
    chk("t3_busy", busy_c, 154);
    chk("t3_erase_cycles", erase_c, 76);
    chk("t3_erase_plot", erase_plot, 75);
    chk("t3_draw_plot", draw_plot, 75);

    // 6: dirty flags
    dirty = 4'b0101;
`ifdef DIRTY_SKIP_EN
    dirty_len = 52;
`else
    dirty_len = 100;
`endif
    run_frame(0, 0, 0);
    dirty = '0;
    chk("t6_erase_cycles", erase_c, dirty_len);
    chk("t6_busy", busy_c, 2*dirty_len + 2);

    // 5: frame_go during DRAW is dropped, flags overrun
    run_frame(0, 0, 10);
    chk("t5_busy", busy_c, 202);
    chk("t5_overrun", int'(overrun), 1);
    repeat (3) step();
    chk("t5_no_extra_frame", int'(busy), 0);
    // async reset in the middle of DRAW
    frame_go = 1; step(); frame_go = 0;
    for (int cyc = 0; cyc < 500 && !(busy && !erase && plot_en && loc == 5'd12); cyc++) step();
    chk("t5_reached_draw", int'(loc), 12);
    #2 reset_n = 0; #1;
    chk("t5_rst_busy", int'(busy), 0);
    chk("t5_rst_outs", int'({init_req, plot_en, erase, load, comp, game_over, overrun}), 0);
    chk("t5_rst_addr", int'({sprite_sel, loc, px, py}), 0);
    step(); reset_n = 1; step();

    // 4: collision at COMP -> blanking erase -> OVER
    run_frame(0, 1, 0);
    chk("t4_erase_cycles", erase_c, 200);
    chk("t4_draw_plot", draw_plot, 100);
    chk("t4_busy", busy_c, 302);
    chk("t4_game_over", int'(game_over), 1);
    chk("t4_plot_off", int'(plot_en), 0);
    frame_go = 1; step(); frame_go = 0;
    repeat (3) step();
    chk("t4_go_ignored", int'({busy, erase, plot_en}), 0);
    chk("t4_still_over", int'(game_over), 1);
    dead = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
